// File: rtl/uart_frame_rx_if.sv
// Byte stream in, framed payload and status out of uart_frame_rx.
// master drives bytes and clr; slave is the frame assembler.
interface uart_frame_rx_if #(
  parameter int NBYTES = 7
);
  logic                  rx_done;
  logic [7:0]            data_byte;
  logic                  clr;
  logic [8*NBYTES-1:0]   frame_data;
  logic                  frame_valid;
  logic                  frame_err;
  logic [1:0]            err_code;
  logic                  busy;
  logic [15:0]           good_cnt;
  logic [7:0]            err_cnt;

  modport master (
    output rx_done, data_byte, clr,
    input  frame_data, frame_valid, frame_err, err_code, busy, good_cnt, err_cnt
  );

  modport slave (
    input  rx_done, data_byte, clr,
    output frame_data, frame_valid, frame_err, err_code, busy, good_cnt, err_cnt
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Header-hunting byte-frame assembler with optional mod-256 checksum and inter-byte timeout.
// Result pulses one cycle after the final byte's strobe; no backpressure, accepts a byte every cycle.
module uart_frame_rx #(
  parameter int          NBYTES      = 7,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter bit          CHECKSUM_EN = 1'b1,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_frame_rx_if.slave bus
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx;
  logic [7:0]          sum;
  logic [TW-1:0]       timer;
  logic [8*NBYTES-1:0] shadow, shadow_nx;
  logic                start, accept, commit, chk_err, tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    accept   = 1'b0;
    commit   = 1'b0;
    chk_err  = 1'b0;
    tmo      = 1'b0;
    if (bus.clr) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.rx_done && bus.data_byte == HEADER) begin
            start    = 1'b1;
            state_nx = PAYLOAD;
          end
        end
        PAYLOAD: begin
          // A header value here is payload; only the byte count ends this state.
          if (bus.rx_done) begin
            accept = 1'b1;
            if (idx == LAST_IDX) begin
              if (CHECKSUM_EN) begin
                state_nx = CHECK;
              end else begin
                state_nx = IDLE;
                commit   = 1'b1;
              end
            end
          end else if (timer == TMAX) begin
            tmo      = 1'b1;
            state_nx = IDLE;
          end
        end
        CHECK: begin
          if (bus.rx_done) begin
            state_nx = IDLE;
            if (bus.data_byte == sum) commit  = 1'b1;
            else                      chk_err = 1'b1;
          end else if (timer == TMAX) begin
            tmo      = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Slot 0 lands in the MSBs so the first received byte leads frame_data.
  always_comb begin
    shadow_nx = shadow;
    if (accept) shadow_nx[8*(NBYTES-1-int'(idx)) +: 8] = bus.data_byte;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      sum             <= '0;
      timer           <= '0;
      shadow          <= '0;
      bus.frame_data  <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.err_code    <= 2'b00;
      bus.good_cnt    <= '0;
      bus.err_cnt     <= '0;
    end else begin
      bus.frame_valid <= commit;
      bus.frame_err   <= chk_err | tmo;
      if (bus.clr) begin
        idx          <= '0;
        sum          <= '0;
        timer        <= '0;
        bus.good_cnt <= '0;
        bus.err_cnt  <= '0;
        bus.err_code <= 2'b00;
      end else begin
        if (start) begin
          idx   <= '0;
          sum   <= '0;
          timer <= '0;
        end else if (accept) begin
          idx    <= idx + 1'b1;
          sum    <= sum + bus.data_byte;
          timer  <= '0;
          shadow <= shadow_nx;
        end else if (state != IDLE && !bus.rx_done && timer != TMAX) begin
          timer <= timer + 1'b1;
        end

        if (commit) begin
          bus.frame_data <= shadow_nx;
          bus.good_cnt   <= bus.good_cnt + 16'd1;
        end
        if (chk_err || tmo) begin
          bus.err_code <= tmo ? 2'b10 : 2'b01;
          if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
        end
      end
    end
  end

endmodule
